bin_to_bcd_seq: RTL and testbench
=================================

Name: bin_to_bcd_seq

Overview:
- Iterative shift-and-add-3 (double-dabble) binary-to-BCD converter.
- Sits directly upstream of the 8-digit multiplexed seven-segment display controller.
- Turns a 32-bit binary value into 8 packed BCD nibbles so the display shows decimal instead of hex.
- Holds the last completed result stable on its output, so the display never sees intermediate shift states.

Parameters:
W, 32, binary input width in bits
DIGITS, 8, number of BCD digits produced; output width is 4*DIGITS

Ports:
bB_clk_i  input  1  system clock; all state updates on rising edge
bB_rst_i  input  1  reset, asynchronous, active-high
bB_start_i  input  1  conversion request; sampled only in IDLE
bB_bin_i  input  W  binary value; sampled on the edge that accepts start
bB_busy_o  output  1  high while a conversion is in progress (SHIFT and DONE states)
bB_done_o  output  1  one-cycle pulse when bB_bcd_o is updated
bB_bcd_o  output  4*DIGITS  packed BCD result; nibble [3:0] = units digit, [4*DIGITS-1:4*DIGITS-4] = most significant digit
bB_ovf_o  output  1  high when the latched result was saturated; updated together with bB_bcd_o
bB_valid_o  output  1  low after reset; set on the first done and held until the next reset

Behaviour:
- Clock and reset: one clock (bB_clk_i); reset bB_rst_i is asynchronous and active-high.
- Reset values: state=IDLE; bB_busy_o=0, bB_done_o=0, bB_bcd_o=0, bB_ovf_o=0, bB_valid_o=0; internal shift register and counter = 0.
- Reset mid-conversion: the conversion is aborted and every output returns to its reset value immediately (asynchronous). The next start is accepted normally after reset deasserts.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - bB_busy_o=0.
  - On an edge with bB_start_i=1, capture the operand and clear the BCD accumulator.
  - Operand = min(bB_bin_i, MAX_VAL), where MAX_VAL = 10^DIGITS-1 (99_999_999 = 0x05F5E0FF for DIGITS=8). Record sat = (bB_bin_i > MAX_VAL).
  - Load bit counter = W, then go to SHIFT.
- SHIFT, one bit per cycle:
  - Every accumulator nibble >= 5 gets +3 (all nibbles evaluated in parallel, combinationally).
  - Then {accumulator, operand} shifts left by 1; the operand MSB enters accumulator bit 0.
  - Counter decrements. When the counter reaches 1 on this edge (the last shift), go to DONE.
- DONE, one cycle:
  - Copy the accumulator into bB_bcd_o and sat into bB_ovf_o.
  - Set bB_valid_o; bB_done_o=1 for this cycle only.
  - Return to IDLE.
- Latency: the start-accept edge is E0. Shifts occur on E1..EW. bB_bcd_o, bB_ovf_o and bB_done_o change on edge E(W+1), i.e. 33 cycles for W=32. The next start can be accepted on E(W+2) at the earliest.
- bB_start_i in SHIFT or DONE is ignored: no queueing and no error flag.
- bB_bin_i changes after acceptance have no effect on the running conversion.
- bB_bcd_o and bB_ovf_o change only on the DONE edge or on reset; they are glitch-free registered outputs.
- Width rule: the accumulator is 4*DIGITS bits. Saturation guarantees no carry is lost out of the top nibble.
- For W < 27 with DIGITS=8, saturation can never trigger; the comparison must still elaborate cleanly.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2), MAX_VAL as a function of DIGITS, and the counter width clog2(W+1).
- One natural sub-module: bcd_add3_nibble. It is 4-bit combinational: out = (in >= 5) ? in+3 : in. Instantiate it DIGITS times via generate.
- FSM, counter and shift register stay in the top module.

Test Plan:
- Reset, then start with bB_bin_i=0 -> 33 cycles later: bB_done_o pulses one cycle, bB_bcd_o=32'h00000000, bB_ovf_o=0, bB_valid_o=1.
- Start with bB_bin_i=12_345_678 (0x00BC614E) -> bB_bcd_o=32'h12345678 exactly on edge E33. bB_busy_o high for edges E1..E33, low again from E34.
- Start with 99_999_999 -> bB_bcd_o=32'h99999999, bB_ovf_o=0. Then start with 32'hFFFFFFFF -> bB_bcd_o=32'h99999999, bB_ovf_o=1. Then start with 10 -> bB_bcd_o=32'h00000010, bB_ovf_o=0.
- Start with 255 and pulse bB_start_i again with 777 at E5 and E33 -> both ignored. Result 32'h00000255, exactly one done pulse. A start with 777 on E34 -> 32'h00000777.
- Complete 4321, then start with 5 and assert bB_rst_i asynchronously at mid-cycle of E10 -> all outputs 0 immediately, including bB_bcd_o (previous 4321 cleared) and bB_valid_o. After release, start with 5 -> 32'h00000005.
- Random regression: 1000 random 32-bit values compared against a software model of min(v, 99_999_999) in decimal and the ovf flag. Check that bB_bcd_o stays stable between done pulses.

Source files
------------

// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// state encoding, saturation limit and counter sizing helpers.
package bin_to_bcd_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   // Largest value representable in the given number of decimal digits (10^digits - 1).
   function automatic logic [63:0] max_val_f(input int digits);
      logic [63:0] p;
      p = 64'd1;
      for (int i = 0; i < digits; i++) begin
         p = p * 64'd10;
      end
      return p - 64'd1;
   endfunction

   function automatic int cnt_width_f(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/bin_to_bcd_seq_add3.sv
// One double-dabble correction cell: a BCD nibble of 5 or more gets +3
// so that the following left shift carries correctly into the next digit.
module bcd_add3_nibble
   import bin_to_bcd_seq_pkg::*;
(
   input  logic [3:0] nib_i,
   output logic [3:0] nib_o
);

   assign nib_o = (nib_i >= 4'd5) ? (nib_i + 4'd3) : nib_i;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Iterative shift-and-add-3 binary-to-BCD converter, one operand bit per cycle.
// The published result only changes on the DONE edge, so downstream logic never sees partial shifts.
module bin_to_bcd_seq
   import bin_to_bcd_seq_pkg::*;
#(
   parameter int W      = 32,
   parameter int DIGITS = 8
) (
   input  logic                  bB_clk_i,
   input  logic                  bB_rst_i,
   input  logic                  bB_start_i,
   input  logic [W-1:0]          bB_bin_i,
   output logic                  bB_busy_o,
   output logic                  bB_done_o,
   output logic [4*DIGITS-1:0]   bB_bcd_o,
   output logic                  bB_ovf_o,
   output logic                  bB_valid_o
);

   localparam int          CW      = cnt_width_f(W);
   localparam int          BW      = 4 * DIGITS;
   localparam int          XW      = (W > 64) ? W : 64;
   localparam logic [63:0] MAX_VAL = max_val_f(DIGITS);

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [BW-1:0]   acc_q, acc_d;
   logic [W-1:0]    opd_q, opd_d;
   logic            sat_q, sat_d;
   logic [BW-1:0]   bcd_q, bcd_d;
   logic            ovf_q, ovf_d;
   logic            valid_q, valid_d;
   logic            done_q, done_d;

   logic [BW-1:0]   acc_adj;
   logic [XW-1:0]   bin_ext;
   logic [XW-1:0]   max_ext;
   logic            sat_in;

   // Comparison is done at a width wide enough for both operands, so narrow W still elaborates.
   assign bin_ext = XW'(bB_bin_i);
   assign max_ext = XW'(MAX_VAL);
   assign sat_in  = (bin_ext > max_ext);

   for (genvar g = 0; g < DIGITS; g++) begin : g_nib
      bcd_add3_nibble u_nib (
         .nib_i (acc_q[4*g +: 4]),
         .nib_o (acc_adj[4*g +: 4])
      );
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      opd_d   = opd_q;
      sat_d   = sat_q;
      bcd_d   = bcd_q;
      ovf_d   = ovf_q;
      valid_d = valid_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bB_start_i) begin
               opd_d   = sat_in ? max_ext[W-1:0] : bB_bin_i;
               sat_d   = sat_in;
               acc_d   = '0;
               cnt_d   = CW'(W);
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            acc_d = {acc_adj[BW-2:0], opd_q[W-1]};
            opd_d = {opd_q[W-2:0], 1'b0};
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            bcd_d   = acc_q;
            ovf_d   = sat_q;
            valid_d = 1'b1;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge bB_clk_i or posedge bB_rst_i) begin
      if (bB_rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         opd_q   <= '0;
         sat_q   <= 1'b0;
         bcd_q   <= '0;
         ovf_q   <= 1'b0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         opd_q   <= opd_d;
         sat_q   <= sat_d;
         bcd_q   <= bcd_d;
         ovf_q   <= ovf_d;
         valid_q <= valid_d;
         done_q  <= done_d;
      end
   end

   assign bB_busy_o  = (state_q != IDLE);
   assign bB_done_o  = done_q;
   assign bB_bcd_o   = bcd_q;
   assign bB_ovf_o   = ovf_q;
   assign bB_valid_o = valid_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: drivers push expected {ovf,bcd} and accept cycle,
// a negedge monitor pops and compares on each done pulse and checks output stability otherwise.
module tb_bin_to_bcd_seq;

   localparam int W      = 32;
   localparam int DIGITS = 8;
   localparam int BW     = 4 * DIGITS;
   localparam int LAT    = W + 1;

   logic          clk;
   logic          rst;
   logic          start;
   logic [W-1:0]  bin;
   logic          busy;
   logic          done;
   logic [BW-1:0] bcd;
   logic          ovf;
   logic          valid;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [BW:0]   exp_q[$];
   int            acc_cyc_q[$];
   logic [BW-1:0] last_bcd;
   logic          last_ovf;
   logic [BW:0]   mon_e;
   int            mon_a;

   bin_to_bcd_seq #(.W(W), .DIGITS(DIGITS)) dut (
      .bB_clk_i   (clk),
      .bB_rst_i   (rst),
      .bB_start_i (start),
      .bB_bin_i   (bin),
      .bB_busy_o  (busy),
      .bB_done_o  (done),
      .bB_bcd_o   (bcd),
      .bB_ovf_o   (ovf),
      .bB_valid_o (valid)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Independent decimal model: saturate, then peel digits with div/mod.
   function automatic logic [BW:0] model(input logic [W-1:0] v);
      logic [BW:0]     r;
      longint unsigned m;
      r = '0;
      if (v > 32'd99_999_999) begin
         r = {1'b1, 32'h9999_9999};
      end else begin
         m = longint'(v);
         for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(m % 10);
            m = m / 10;
         end
      end
      return r;
   endfunction

   // scoreboard monitor
   always @(negedge clk) begin
      if (rst) begin
         last_bcd = '0;
         last_ovf = 1'b0;
      end else if (done) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: got bcd=%h ovf=%0d, expected no done pulse", bcd, ovf);
         end else begin
            mon_e = exp_q.pop_front();
            mon_a = acc_cyc_q.pop_front();
            chk("bcd", 64'(bcd), 64'(mon_e[BW-1:0]));
            chk("ovf", 64'(ovf), 64'(mon_e[BW]));
            chk("latency", 64'(cyc - mon_a), 64'(LAT));
            chk("valid_at_done", 64'(valid), 64'd1);
         end
         last_bcd = bcd;
         last_ovf = ovf;
      end else begin
         chk("bcd_stable", 64'({ovf, bcd}), 64'({last_ovf, last_bcd}));
      end
   end

   // drivers (called at a negedge)
   task automatic issue(input logic [W-1:0] v, input logic [BW:0] e);
      int n = 0;
      while (busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (busy) begin
         total++;
         bad++;
         $display("FAIL issue_timeout: busy=%0d expected 0 before start", busy);
      end
      start = 1'b1;
      bin   = v;
      exp_q.push_back(e);
      acc_cyc_q.push_back(cyc + 1);
      @(negedge clk);
      start = 1'b0;
      bin   = $urandom;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL done_timeout: pending=%0d expected 0", exp_q.size());
         exp_q.delete();
         acc_cyc_q.delete();
      end
      @(negedge clk);
   endtask

   logic [W-1:0] rv;

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      bin   = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy",  64'(busy),  64'd0);
      chk("rst_done",  64'(done),  64'd0);
      chk("rst_bcd",   64'(bcd),   64'd0);
      chk("rst_ovf",   64'(ovf),   64'd0);
      chk("rst_valid", 64'(valid), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      issue(32'd0, {1'b0, 32'h0000_0000});
      wait_idle();
      chk("valid_set", 64'(valid), 64'd1);

      // busy window for 12_345_678
      issue(32'h00BC_614E, {1'b0, 32'h1234_5678});
      chk("busy_e0", 64'(busy), 64'd1);
      for (int k = 1; k <= W; k++) begin
         @(negedge clk);
         chk("busy_run", 64'(busy), 64'd1);
      end
      @(negedge clk);
      chk("busy_end", 64'(busy), 64'd0);
      wait_idle();

      issue(32'd99_999_999, {1'b0, 32'h9999_9999});
      wait_idle();
      issue(32'hFFFF_FFFF, {1'b1, 32'h9999_9999});
      wait_idle();
      issue(32'd100_000_000, {1'b1, 32'h9999_9999});
      wait_idle();
      issue(32'd10, {1'b0, 32'h0000_0010});
      wait_idle();

      // starts during SHIFT (E5) and DONE (E33) are ignored; E34 start is taken
      issue(32'd255, {1'b0, 32'h0000_0255});
      repeat (4) @(negedge clk);
      start = 1'b1;
      bin   = 32'd777;
      @(negedge clk);
      start = 1'b0;
      repeat (27) @(negedge clk);
      start = 1'b1;
      bin   = 32'd777;
      @(negedge clk);
      start = 1'b0;
      issue(32'd777, {1'b0, 32'h0000_0777});
      wait_idle();
      repeat (40) @(negedge clk);

      // asynchronous reset mid-conversion
      issue(32'd4321, {1'b0, 32'h0000_4321});
      wait_idle();
      issue(32'd5, {1'b0, 32'h0000_0005});
      repeat (10) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_busy",  64'(busy),  64'd0);
      chk("arst_done",  64'(done),  64'd0);
      chk("arst_bcd",   64'(bcd),   64'd0);
      chk("arst_ovf",   64'(ovf),   64'd0);
      chk("arst_valid", 64'(valid), 64'd0);
      exp_q.delete();
      acc_cyc_q.delete();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      issue(32'd5, {1'b0, 32'h0000_0005});
      wait_idle();

      // random regression against the decimal model
      for (int i = 0; i < 1000; i++) begin
         rv = (i % 2 == 1) ? W'($urandom) : W'($urandom_range(0, 120_000_000));
         issue(rv, model(rv));
         wait_idle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
